// File: rtl/pc_redirect_unit_pkg.sv
// Shared state encodings and constants for the PC redirect unit.
package pc_redirect_unit_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Clears bit 0 of a JALR target; sliced to XLEN at the use site (XLEN <= 64).
    localparam logic [63:0] INSTR_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFE;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter used for branch/redirect statistics.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, branch/jump redirect, flush generation,
// and deferral of a redirect while instruction memory is busy.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned    CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    output logic [XLEN-1:0]  pc,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             misaligned,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] raw_tgt;
    logic [XLEN-1:0] tgt;
    logic            req;
    logic            tgt_bad;
    logic            br_inc;
    logic            tk_inc;

    assign req     = ex_valid & (ex_jal | ((ex_branch | ex_jalr) & br_taken));
    assign raw_tgt = ex_jalr ? ((ex_rs1 + ex_imm) & INSTR_ALIGN_MASK[XLEN-1:0])
                             : (ex_pc + ex_imm);
    assign tgt_bad = raw_tgt[1];
    assign tgt     = tgt_bad ? TRAP_VEC : raw_tgt;
    assign pc      = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        misaligned  = 1'b0;
        br_inc      = 1'b0;
        tk_inc      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                br_inc = ex_valid & ex_branch;
                // A redirect is older than whatever the hazard unit is stalling.
                if (req) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    misaligned  = tgt_bad;
                    tk_inc      = 1'b1;
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = ST_PEND;
                    end
                end else if (!stall && imem_ready) begin
                    pc_d = pc_q + XLEN'(PC_STEP);
                end
            end
            ST_PEND: begin
                if_id_flush = 1'b1;
                if (imem_ready) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Reset discards everything, including the flush a pending redirect would hold.
        if (rst) begin
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            misaligned  = 1'b0;
            br_inc      = 1'b0;
            tk_inc      = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (br_inc),
        .cnt (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (tk_inc),
        .cnt (taken_cnt)
    );

    // EX must hold a bubble while a redirect is pending.
    always @(posedge clk) begin
        if (!rst && (state_q == ST_PEND)) begin
            assert (!req);
        end
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and consumes the taken/not-taken result (`br_taken`) that the branch condition logic produces in EX.
- Computes the redirect target for branches, JAL and JALR, and generates the pipeline flush pulses.
- Holds the PC on hazard stalls and on instruction-memory back-pressure.
- Latches a redirect that arrives while fetch is busy and applies it later.
- Sits between the EX-stage branch condition logic and the IF stage.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect target.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hazard-unit load-use stall; hold PC
- imem_ready  input  1  instruction memory accepts the fetch at `pc` this cycle
- ex_valid  input  1  EX holds a real (non-bubble) instruction
- ex_branch  input  1  EX instruction is a conditional branch
- ex_jal  input  1  EX instruction is JAL
- ex_jalr  input  1  EX instruction is JALR
- br_taken  input  1  condition result from branch logic; already high for JALR
- ex_pc  input  XLEN  PC of the EX instruction
- ex_imm  input  XLEN  sign-extended immediate
- ex_rs1  input  XLEN  forwarded rs1 value
- pc  output  XLEN  current fetch address
- if_id_flush  output  1  squash the IF/ID register at the next edge
- id_ex_flush  output  1  squash the ID/EX register at the next edge
- misaligned  output  1  one-cycle pulse: redirect target had bit 1 set
- branch_cnt  output  CNT_W  number of resolved conditional branches
- taken_cnt  output  CNT_W  number of taken redirects, including jumps

Behaviour:
- Reset (synchronous):
  - `pc` = RESET_PC and state = RUN.
  - `pend_tgt` = 0 and both counters = 0.
  - `misaligned` = 0 and both flushes = 0.
  - Reset overrides everything else, including a pending redirect, which is discarded.
- `req` = `ex_valid` & (`ex_jal` | ((`ex_branch` | `ex_jalr`) & `br_taken`)).
- Raw target: `ex_jalr` gives (`ex_rs1` + `ex_imm`) & ~1; otherwise `ex_pc` + `ex_imm`. Arithmetic is modulo 2^XLEN and wrap-around is silent.
- If raw target bit 1 = 1: `tgt` = TRAP_VEC and `misaligned` pulses in the request cycle. Otherwise `tgt` = raw target.
- States:
  - RUN: normal fetch.
  - PEND: a redirect is accepted but not yet applied because fetch was busy.
- RUN, cycle N with `req` = 1:
  - `if_id_flush` = `id_ex_flush` = 1 combinationally in cycle N.
  - If `imem_ready` = 1: `pc` <= `tgt`, so `pc` = `tgt` in N+1, and stay in RUN.
  - If `imem_ready` = 0: `pend_tgt` <= `tgt` and go to PEND.
  - `req` overrides `stall`: the redirecting instruction is older than the stalled one.
- RUN, `req` = 0:
  - If `stall` = 1 or `imem_ready` = 0, hold `pc`.
  - Otherwise `pc` <= `pc` + 4.
  - Flushes = 0.
- PEND:
  - `if_id_flush` is held at 1 every cycle and `id_ex_flush` = 0.
  - `stall` is ignored.
  - On the first cycle with `imem_ready` = 1: `pc` <= `pend_tgt` and go to RUN.
  - `req` cannot occur in PEND because EX holds a bubble. If it does occur, ignore it and fire a simulation assertion.
- Counters:
  - `branch_cnt` increments when `ex_valid` & `ex_branch` and the instruction is accepted, i.e. not in PEND.
  - `taken_cnt` increments on every accepted `req`.
  - Both saturate at all-ones.
- Reset asserted mid-PEND returns to RUN with `pc` = RESET_PC, and no flush output is asserted in the reset cycle.

Decomposition:
- Shared include file for the state encodings ST_RUN and ST_PEND, and for the INSTR_ALIGN_MASK constant.
- One sub-module, `sat_counter`, is natural: parameterized width, `inc` input, saturates at max. It is instantiated twice.

Test Plan:
- Reset then 3 free-run cycles, `imem_ready` = 1 -> `pc` sequence 0x0, 0x4, 0x8, 0xC, with no flushes.
- Taken branch: `ex_pc` = 0x20, `ex_imm` = 0x40, `br_taken` = 1, `imem_ready` = 1 -> both flushes high that cycle, `pc` = 0x60 next cycle, `branch_cnt` = 1, `taken_cnt` = 1.
- JALR: `ex_rs1` = 0x1001, `ex_imm` = 0x4 -> `pc` = 0x1004 (bit 0 cleared). With `ex_rs1` = 0x1002 and `ex_imm` = 0 -> `misaligned` pulse, `pc` = 0x100.
- Redirect with `imem_ready` low for 3 cycles, target 0x80 -> PEND held 3 cycles with `if_id_flush` = 1 and `pc` frozen. `pc` = 0x80 the cycle after ready rises.
- `stall` = 1 together with a taken JAL to 0x200 -> redirect wins, `pc` = 0x200. `stall` alone -> `pc` held.
- Assert `rst` during PEND -> `pc` = 0x0, state RUN, counters 0, and the pending target is never applied.
